// File: rtl/control_unit.sv
// Mini-SRC hardwired control sequencer.
// Fetch in T0-T2, opcode-dependent execute in T3-T7.
module control_unit (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        ZLowin,
  output logic        ZLowout,
  output logic        Cout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  OP,
  output logic        Run
);

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00100;
  localparam logic [4:0] ALU_AND = 5'b00110;
  localparam logic [4:0] ALU_OR  = 5'b00111;

  state_t state;
  state_t state_nx;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;

  logic is_alu;
  logic is_imm;
  logic is_ld;
  logic is_st;
  logic is_halt;
  logic is_exec;

  assign opcode = IR[31:27];
  assign ra     = IR[26:23];
  assign rb     = IR[22:19];
  assign rc     = IR[18:15];

  assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd11);
  assign is_imm  = (opcode == OPC_ADDI) || (opcode == OPC_ANDI) ||
                   (opcode == OPC_ORI)  || (opcode == OPC_LDI);
  assign is_ld   = (opcode == OPC_LD);
  assign is_st   = (opcode == OPC_ST);
  assign is_halt = (opcode == OPC_HALT);
  assign is_exec = is_alu || is_imm || is_ld || is_st;

  // State register; Clear forces RESET at any point in an instruction
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state <= S_RESET;
    else       state <= state_nx;
  end

  // Next-state sequencing and per-step datapath strobes
  always_comb begin
    state_nx = state;
    Rin      = '0;
    Rout     = '0;
    PCin     = 1'b0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    IRin     = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    Yin      = 1'b0;
    ZLowin   = 1'b0;
    ZLowout  = 1'b0;
    Cout     = 1'b0;
    Read     = 1'b0;
    Write    = 1'b0;
    OP       = '0;
    Run      = 1'b1;

    case (state)
      S_RESET: begin
        Run      = 1'b0;
        state_nx = S_T0;
      end
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        ZLowin   = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        ZLowout  = 1'b1;
        PCin     = 1'b1;
        Read     = 1'b1;
        MDRin    = 1'b1;
        state_nx = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (is_exec)      state_nx = S_T3;
        else if (is_halt) state_nx = S_HALT;
        else              state_nx = S_T0;
      end
      S_T3: begin
        Rout     = 16'(1) << rb;
        Yin      = 1'b1;
        state_nx = S_T4;
      end
      S_T4: begin
        ZLowin = 1'b1;
        if (is_alu) Rout = 16'(1) << rc;
        else        Cout = 1'b1;
        unique case (1'b1)
          is_alu:               OP = opcode + 5'd1;
          (opcode == OPC_ANDI): OP = ALU_AND;
          (opcode == OPC_ORI):  OP = ALU_OR;
          default:              OP = ALU_ADD;
        endcase
        state_nx = S_T5;
      end
      S_T5: begin
        ZLowout = 1'b1;
        if (is_ld || is_st) begin
          MARin    = 1'b1;
          state_nx = S_T6;
        end else begin
          Rin      = 16'(1) << ra;
          state_nx = S_T0;
        end
      end
      S_T6: begin
        MDRin = 1'b1;
        if (is_st) Rout = 16'(1) << ra;
        else       Read = 1'b1;
        state_nx = S_T7;
      end
      S_T7: begin
        if (is_st) begin
          Write = 1'b1;
        end else begin
          MDRout = 1'b1;
          Rin    = 16'(1) << ra;
        end
        state_nx = S_T0;
      end
      S_HALT: begin
        Run      = 1'b0;
        state_nx = S_HALT;
      end
      default: begin
        Run      = 1'b0;
        state_nx = S_RESET;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios plus
// random instructions against a step-table model.
module tb_control_unit;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcin;
    logic        pcout;
    logic        incpc;
    logic        irin;
    logic        marin;
    logic        mdrin;
    logic        mdrout;
    logic        yin;
    logic        zlowin;
    logic        zlowout;
    logic        cout;
    logic        rd;
    logic        wr;
    logic [4:0]  op;
    logic        run;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = '0;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCin;
  logic        PCout;
  logic        IncPC;
  logic        IRin;
  logic        MARin;
  logic        MDRin;
  logic        MDRout;
  logic        Yin;
  logic        ZLowin;
  logic        ZLowout;
  logic        Cout;
  logic        Read;
  logic        Write;
  logic [4:0]  OP;
  logic        Run;

  int vectors = 0;
  int errors  = 0;

  vec_t exp_seq [8];
  int   exp_len;

  control_unit dut (
    .Clock   (Clock),
    .Clear   (Clear),
    .IR      (IR),
    .Rin     (Rin),
    .Rout    (Rout),
    .PCin    (PCin),
    .PCout   (PCout),
    .IncPC   (IncPC),
    .IRin    (IRin),
    .MARin   (MARin),
    .MDRin   (MDRin),
    .MDRout  (MDRout),
    .Yin     (Yin),
    .ZLowin  (ZLowin),
    .ZLowout (ZLowout),
    .Cout    (Cout),
    .Read    (Read),
    .Write   (Write),
    .OP      (OP),
    .Run     (Run)
  );

  always #5 Clock = ~Clock;

  function automatic vec_t observe();
    return vec_t'({Rin, Rout, PCin, PCout, IncPC, IRin,
                   MARin, MDRin, MDRout, Yin, ZLowin,
                   ZLowout, Cout, Read, Write, OP, Run});
  endfunction

  // Per-instruction list of expected output vectors, one per cycle
  task automatic build_expected(input logic [31:0] ir);
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    bit alu, imm, ld, st;
    vec_t v;
    opc = ir[31:27];
    ra  = ir[26:23];
    rb  = ir[22:19];
    rc  = ir[18:15];
    alu = (opc >= 3) && (opc <= 11);
    imm = (opc == 12) || (opc == 13) || (opc == 14) || (opc == 1);
    ld  = (opc == 0);
    st  = (opc == 2);
    for (int i = 0; i < 8; i++) begin
      exp_seq[i]     = '0;
      exp_seq[i].run = 1'b1;
    end
    exp_seq[0].pcout   = 1; exp_seq[0].marin = 1;
    exp_seq[0].incpc   = 1; exp_seq[0].zlowin = 1;
    exp_seq[1].zlowout = 1; exp_seq[1].pcin = 1;
    exp_seq[1].rd      = 1; exp_seq[1].mdrin = 1;
    exp_seq[2].mdrout  = 1; exp_seq[2].irin = 1;
    exp_len = 3;
    if (alu || imm || ld || st) begin
      exp_seq[3].rout = 16'h1 << rb;
      exp_seq[3].yin  = 1;
      v = exp_seq[4];
      v.zlowin = 1;
      if (alu) begin
        v.rout = 16'h1 << rc;
        v.op   = opc + 5'd1;
      end else begin
        v.cout = 1;
        v.op   = (opc == 13) ? 5'd6 : (opc == 14) ? 5'd7 : 5'd4;
      end
      exp_seq[4] = v;
      exp_seq[5].zlowout = 1;
      exp_len = 6;
      if (ld || st) begin
        exp_seq[5].marin = 1;
        exp_seq[6].mdrin = 1;
        if (ld) begin
          exp_seq[6].rd     = 1;
          exp_seq[7].mdrout = 1;
          exp_seq[7].rin    = 16'h1 << ra;
        end else begin
          exp_seq[6].rout = 16'h1 << ra;
          exp_seq[7].wr   = 1;
        end
        exp_len = 8;
      end else begin
        exp_seq[5].rin = 16'h1 << ra;
      end
    end
  endtask

  task automatic test_reset();
    Clear = 1'b1;
    IR    = '0;
    repeat (2) @(negedge Clock);
    vectors++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL reset_idle got=%h exp=0", observe());
    end
    Clear = 1'b0;
    @(negedge Clock);
    IR = {5'd3, 4'd4, 4'd5, 4'd6, 15'd0};
    repeat (4) @(negedge Clock);
    vectors++;
    if ({Rout, OP, ZLowin} !== {16'h0040, 5'd4, 1'b1}) begin
      errors++;
      $display("FAIL reset_add_t4 got=%h/%b/%b exp=0040/00100/1",
               Rout, OP, ZLowin);
    end
    Clear = 1'b1;
    #1;
    vectors++;
    if (observe() !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", observe());
    end
    @(negedge Clock);
    Clear = 1'b0;
    @(negedge Clock);
    vectors++;
    if ({PCout, MARin, IncPC, ZLowin, Run} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_release_t0 got=%b exp=11111",
               {PCout, MARin, IncPC, ZLowin, Run});
    end
  endtask

  task automatic test_shr();
    IR = 32'h389A8000;
    repeat (3) @(negedge Clock);
    vectors++;
    if ({Rout, Yin, Rin} !== {16'h0008, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL shr_t3 got=%h/%b/%h exp=0008/1/0000", Rout, Yin, Rin);
    end
    @(negedge Clock);
    vectors++;
    if ({Rout, OP, ZLowin} !== {16'h0020, 5'b01000, 1'b1}) begin
      errors++;
      $display("FAIL shr_t4 got=%h/%b/%b exp=0020/01000/1",
               Rout, OP, ZLowin);
    end
    @(negedge Clock);
    vectors++;
    if ({ZLowout, Rin, Rout, OP} !== {1'b1, 16'h0002, 16'h0, 5'd0}) begin
      errors++;
      $display("FAIL shr_t5 got=%b/%h/%h/%b exp=1/0002/0000/00000",
               ZLowout, Rin, Rout, OP);
    end
    @(negedge Clock);
    vectors++;
    if ({PCout, IncPC, Yin} !== 3'b110) begin
      errors++;
      $display("FAIL shr_next_t0 got=%b exp=110", {PCout, IncPC, Yin});
    end
  endtask

  task automatic test_addi();
    IR = 32'h61180005;
    repeat (4) @(negedge Clock);
    vectors++;
    if ({Cout, Rout, OP} !== {1'b1, 16'h0, 5'b00100}) begin
      errors++;
      $display("FAIL addi_t4 got=%b/%h/%b exp=1/0000/00100", Cout, Rout, OP);
    end
    @(negedge Clock);
    vectors++;
    if ({Rin, ZLowout} !== {16'h0004, 1'b1}) begin
      errors++;
      $display("FAIL addi_t5 got=%h/%b exp=0004/1", Rin, ZLowout);
    end
    @(negedge Clock);
  endtask

  task automatic test_ld();
    IR = 32'h00800050;
    repeat (5) @(negedge Clock);
    vectors++;
    if ({MARin, ZLowout, Rin} !== {1'b1, 1'b1, 16'h0}) begin
      errors++;
      $display("FAIL ld_t5 got=%b/%b/%h exp=1/1/0000", MARin, ZLowout, Rin);
    end
    @(negedge Clock);
    vectors++;
    if ({Read, MDRin} !== 2'b11) begin
      errors++;
      $display("FAIL ld_t6 got=%b exp=11", {Read, MDRin});
    end
    @(negedge Clock);
    vectors++;
    if ({MDRout, Rin, PCout} !== {1'b1, 16'h0002, 1'b0}) begin
      errors++;
      $display("FAIL ld_t7 got=%b/%h/%b exp=1/0002/0", MDRout, Rin, PCout);
    end
    @(negedge Clock);
    vectors++;
    if ({PCout, MARin, IncPC, ZLowin} !== 4'b1111) begin
      errors++;
      $display("FAIL ld_len8 got=%b exp=1111",
               {PCout, MARin, IncPC, ZLowin});
    end
  endtask

  task automatic test_st();
    IR = 32'h11000090;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge Clock);
      vectors++;
      if (Write !== (i == 7)) begin
        errors++;
        $display("FAIL st_write_step%0d got=%b exp=%b", i, Write, i == 7);
      end
      if (i == 6) begin
        vectors++;
        if ({Rout, MDRin, Read, Rin} !== {16'h0004, 1'b1, 1'b0, 16'h0}) begin
          errors++;
          $display("FAIL st_t6 got=%h/%b/%b/%h exp=0004/1/0/0000",
                   Rout, MDRin, Read, Rin);
        end
      end
    end
    @(negedge Clock);
    vectors++;
    if ({PCout, Write} !== 2'b10) begin
      errors++;
      $display("FAIL st_next_t0 got=%b exp=10", {PCout, Write});
    end
  endtask

  task automatic test_nop();
    IR = 32'hD0000000;
    repeat (2) @(negedge Clock);
    vectors++;
    if ({MDRout, IRin} !== 2'b11) begin
      errors++;
      $display("FAIL nop_t2 got=%b exp=11", {MDRout, IRin});
    end
    @(negedge Clock);
    vectors++;
    if ({PCout, Yin, Run} !== 3'b101) begin
      errors++;
      $display("FAIL nop_back_t0 got=%b exp=101", {PCout, Yin, Run});
    end
  endtask

  task automatic test_halt();
    IR = 32'hD8000000;
    repeat (3) @(negedge Clock);
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (observe() !== '0) begin
        errors++;
        $display("FAIL halt_cycle%0d got=%h exp=0", i, observe());
      end
      @(negedge Clock);
    end
    Clear = 1'b1;
    @(negedge Clock);
    Clear = 1'b0;
    IR    = '0;
    @(negedge Clock);
    vectors++;
    if ({PCout, Run} !== 2'b11) begin
      errors++;
      $display("FAIL halt_clear_t0 got=%b exp=11", {PCout, Run});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [4:0]  opc;
    for (int n = 0; n < 80; n++) begin
      r = $urandom();
      if ($urandom_range(0, 9) < 8) opc = 5'($urandom_range(0, 14));
      else                          opc = 5'($urandom_range(15, 31));
      if (opc == 5'd27) opc = 5'd26;
      IR = {opc, r[26:0]};
      build_expected(IR);
      for (int i = 0; i < exp_len; i++) begin
        if (i > 0) @(negedge Clock);
        vectors++;
        if (observe() !== exp_seq[i]) begin
          errors++;
          $display("FAIL rand_step%0d ir=%h got=%h exp=%h",
                   i, IR, observe(), exp_seq[i]);
        end
      end
      @(negedge Clock);
    end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_addi();
    test_ld();
    test_st();
    test_nop();
    test_halt();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
